// File: rtl/axis_stream_checker.sv
// axis_stream_checker: sinks an AXI-Stream, compares every sample with a golden
// RAM entry, checks tlast placement, shapes back-pressure and runs a stall
// watchdog. Results stay on the status outputs until the next accepted start.
//
// Handshake: a sample transfers on a rising edge where sm_tvalid & sm_tready;
// sm_tready depends only on registered state (never on sm_tvalid), and data
// presented while sm_tready is low is ignored entirely.
module axis_stream_checker #(
    parameter int pDATA_WIDTH = 32,
    parameter int pADDR_WIDTH = 12,
    parameter int pCNT_WIDTH  = 16,
    parameter int pWDOG_WIDTH = 20
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [pCNT_WIDTH-1:0]  length,
    input  logic [1:0]             bp_mode,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   sm_tready,
    output logic                   gold_EN,
    output logic [pADDR_WIDTH-1:0] gold_A,
    input  logic [pDATA_WIDTH-1:0] gold_Do,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [pCNT_WIDTH-1:0]  err_cnt,
    output logic [pCNT_WIDTH-1:0]  first_err_idx,
    output logic [pDATA_WIDTH-1:0] first_err_got,
    output logic [pDATA_WIDTH-1:0] first_err_exp,
    output logic                   tlast_err,
    output logic                   timeout,
    output logic [2:0]             fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_ACCEPT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Watchdog fires when the idle count would reach all-ones.
    localparam logic [pWDOG_WIDTH-1:0] WDOG_LAST = {{(pWDOG_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [15:0]            LFSR_SEED = 16'hACE1;

    state_t                 state;
    state_t                 state_nxt;
    logic [pCNT_WIDTH-1:0]  len_q;
    logic [pCNT_WIDTH-1:0]  idx;
    logic [pCNT_WIDTH-1:0]  idx_nxt;
    logic [1:0]             mode_q;
    logic [pDATA_WIDTH-1:0] gold_q;
    logic [pWDOG_WIDTH-1:0] wdog;
    logic                   t;
    logic [15:0]            lfsr;
    logic                   start_ok;
    logic                   hs;
    logic                   at_last;
    logic                   wdog_exp;
    logic                   advance;

    assign start_ok = start & ((state == S_IDLE) | (state == S_DONE));
    assign hs       = sm_tvalid & sm_tready;
    assign at_last  = (idx == (len_q - pCNT_WIDTH'(1)));
    assign idx_nxt  = idx + pCNT_WIDTH'(1);
    assign wdog_exp = (state == S_ACCEPT) & ~hs & (wdog == WDOG_LAST);
    assign advance  = (state == S_ACCEPT) & hs & ~at_last;

    // State register
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state <= S_IDLE;
        else             state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) state_nxt = (length != '0) ? S_FETCH : S_DONE;
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ACCEPT;
            S_ACCEPT: begin
                if (hs)            state_nxt = at_last ? S_DONE : S_LOAD;
                else if (wdog_exp) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Back-pressure: ready only in ACCEPT, shaped by the latched mode
    always_comb begin
        sm_tready = 1'b0;
        if (state == S_ACCEPT) begin
            case (mode_q)
                2'd1:    sm_tready = t;
                2'd2:    sm_tready = lfsr[0];
                default: sm_tready = 1'b1;
            endcase
        end
    end

    // Golden RAM addressing and status decode
    always_comb begin
        gold_EN   = 1'b0;
        gold_A    = '0;
        if (state == S_FETCH) begin
            gold_EN = 1'b1;
            gold_A  = pADDR_WIDTH'({idx, 2'b00});
        end else if (advance) begin
            gold_EN = 1'b1;
            gold_A  = pADDR_WIDTH'({idx_nxt, 2'b00});
        end
        busy      = (state == S_FETCH) | (state == S_LOAD) | (state == S_ACCEPT);
        done      = (state == S_DONE);
        pass      = done & (err_cnt == '0) & ~tlast_err & ~timeout;
        fsm_state = state;
    end

    // Free-running back-pressure sources: toggle bit and 16-bit Fibonacci LFSR
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            t    <= 1'b0;
            lfsr <= LFSR_SEED;
        end else begin
            t    <= ~t;
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // Run context, golden latch, watchdog and result registers
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            len_q         <= '0;
            mode_q        <= '0;
            idx           <= '0;
            gold_q        <= '0;
            wdog          <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            tlast_err     <= 1'b0;
            timeout       <= 1'b0;
        end else if (start_ok) begin
            len_q         <= length;
            mode_q        <= bp_mode;
            idx           <= '0;
            wdog          <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            tlast_err     <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            if (state == S_LOAD) gold_q <= gold_Do;
            if (state == S_ACCEPT) begin
                if (hs) begin
                    wdog <= '0;
                    if (sm_tdata != gold_q) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + pCNT_WIDTH'(1);
                        // err_cnt saturates, so zero reliably marks "no mismatch yet"
                        if (err_cnt == '0) begin
                            first_err_idx <= idx;
                            first_err_got <= sm_tdata;
                            first_err_exp <= gold_q;
                        end
                    end
                    if (sm_tlast != at_last) tlast_err <= 1'b1;
                    if (!at_last) idx <= idx_nxt;
                end else begin
                    wdog <= wdog + pWDOG_WIDTH'(1);
                    if (wdog_exp) timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_stream_checker.sv
// Testbench for axis_stream_checker: table of directed runs with hand-derived
// expectations, randomized runs scored by a sample-level reference model, and
// hand-written reset / zero-length sequences.
module tb_axis_stream_checker;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int CW = 16;
    localparam int WW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] length;
    logic [1:0]    bp_mode;
    logic          sm_tvalid;
    logic [DW-1:0] sm_tdata;
    logic          sm_tlast;
    logic          sm_tready;
    logic          gold_EN;
    logic [AW-1:0] gold_A;
    logic [DW-1:0] gold_Do = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] first_err_idx;
    logic [DW-1:0] first_err_got;
    logic [DW-1:0] first_err_exp;
    logic          tlast_err;
    logic          timeout;
    logic [2:0]    fsm_state;

    int vectors     = 0;
    int miscompares = 0;

    // clock / reset
    always #5 clk = ~clk;

    axis_stream_checker #(
        .pDATA_WIDTH(DW), .pADDR_WIDTH(AW), .pCNT_WIDTH(CW), .pWDOG_WIDTH(WW)
    ) dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .start(start), .length(length),
        .bp_mode(bp_mode), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata),
        .sm_tlast(sm_tlast), .sm_tready(sm_tready), .gold_EN(gold_EN),
        .gold_A(gold_A), .gold_Do(gold_Do), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
        .first_err_got(first_err_got), .first_err_exp(first_err_exp),
        .tlast_err(tlast_err), .timeout(timeout), .fsm_state(fsm_state)
    );

    // Golden RAM: word-addressed, data one cycle after enable
    logic [DW-1:0] gold_mem [0:1023];
    always @(posedge clk) if (gold_EN) gold_Do <= gold_mem[gold_A[AW-1:2]];

    // Back-pressure pattern references: toggle bit and ACE1 LFSR (taps 16,14,13,11)
    logic        m_t;
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    <= 1'b0;
            m_lfsr <= 16'hACE1;
        end else begin
            m_t    <= ~m_t;
            m_lfsr <= {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
        end
    end

    // Stream contents for the current run
    logic [DW-1:0] s_data [0:63];
    logic          s_last [0:63];

    typedef struct {
        int          len;
        int          mode;
        bit          rnd;
        int          err_a;
        logic [31:0] val_a;
        int          err_b;
        logic [31:0] val_b;
        int          tlast_at;
        int          stall;
        bit          poke;
        bit          exp_pass;
        int          exp_err;
        int          exp_fidx;
        logic [31:0] exp_fgot;
        logic [31:0] exp_fexp;
        bit          exp_tlast;
        bit          exp_to;
        int          exp_hs;
        int          exp_gap;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".tready"},    sm_tready, 0);
        chk({tag, ".gold_EN"},   gold_EN, 0);
        chk({tag, ".gold_A"},    gold_A, 0);
        chk({tag, ".busy"},      busy, 0);
        chk({tag, ".done"},      done, 0);
        chk({tag, ".pass"},      pass, 0);
        chk({tag, ".err_cnt"},   err_cnt, 0);
        chk({tag, ".fidx"},      first_err_idx, 0);
        chk({tag, ".fgot"},      first_err_got, 0);
        chk({tag, ".fexp"},      first_err_exp, 0);
        chk({tag, ".tlast_err"}, tlast_err, 0);
        chk({tag, ".timeout"},   timeout, 0);
        chk({tag, ".state"},     fsm_state, 0);
    endtask

    // Reference model: expected results from the samples that will be offered
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   n = (v.stall < 0 || v.stall > v.len) ? v.len : v.stall;
        r.exp_err = 0; r.exp_fidx = 0; r.exp_fgot = 0; r.exp_fexp = 0;
        r.exp_tlast = 0;
        for (int i = 0; i < n; i++) begin
            if (s_data[i] != gold_mem[i]) begin
                if (r.exp_err == 0) begin
                    r.exp_fidx = i; r.exp_fgot = s_data[i]; r.exp_fexp = gold_mem[i];
                end
                r.exp_err++;
            end
            if (s_last[i] != (i == v.len - 1)) r.exp_tlast = 1;
        end
        r.exp_to   = (n < v.len);
        r.exp_hs   = n;
        r.exp_gap  = r.exp_to ? (1 << WW) + 1 : 1;
        r.exp_pass = (r.exp_err == 0) && !r.exp_tlast && !r.exp_to;
        return r;
    endfunction

    // Driver + per-cycle checks for one run; results compared once done rises
    task automatic run_vec(input vec_t v, input string tag);
        int cyc = 0, sent = 0, hs_cnt = 0, last_hs = -1;
        int gap_bad = 0, patt_bad = 0, early_bad = 0;
        bit ok;
        @(negedge clk);
        start = 1'b1; length = CW'(v.len); bp_mode = 2'(v.mode); sm_tvalid = 1'b0;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        chk({tag, ".busy_after_start"}, busy, 1);
        chk({tag, ".done_cleared"}, done, 0);
        while (done !== 1'b1 && cyc < 2000) begin
            if (sm_tready) begin
                if (cyc < 3) early_bad++;
                if (last_hs >= 0 && cyc == last_hs + 1) early_bad++;
                if (v.mode == 1 && !m_t) patt_bad++;
                if (v.mode == 2 && !m_lfsr[0]) patt_bad++;
            end
            if (v.poke && cyc == 5) begin
                start = 1'b1; length = CW'(2);
            end else begin
                start = 1'b0;
            end
            ok = (sent < v.len) && (v.stall < 0 || sent < v.stall) &&
                 (!v.rnd || $urandom_range(0, 3) != 0);
            if (ok) begin
                sm_tvalid = 1'b1; sm_tdata = s_data[sent]; sm_tlast = s_last[sent];
            end else begin
                sm_tvalid = 1'b0; sm_tdata = $urandom; sm_tlast = 1'($urandom_range(0, 1));
            end
            if (sm_tvalid && sm_tready) begin
                if (v.mode == 0 && !v.rnd) begin
                    if (last_hs < 0 && cyc != 3) gap_bad++;
                    if (last_hs >= 0 && cyc - last_hs != 2) gap_bad++;
                end
                last_hs = cyc; sent++; hs_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; sm_tvalid = 1'b0;
        chk({tag, ".done"},      done, 1);
        chk({tag, ".busy"},      busy, 0);
        chk({tag, ".pass"},      pass, v.exp_pass);
        chk({tag, ".err_cnt"},   err_cnt, v.exp_err);
        chk({tag, ".fidx"},      first_err_idx, v.exp_fidx);
        chk({tag, ".fgot"},      first_err_got, v.exp_fgot);
        chk({tag, ".fexp"},      first_err_exp, v.exp_fexp);
        chk({tag, ".tlast_err"}, tlast_err, v.exp_tlast);
        chk({tag, ".timeout"},   timeout, v.exp_to);
        chk({tag, ".handshakes"}, hs_cnt, v.exp_hs);
        chk({tag, ".done_gap"},  cyc - last_hs, v.exp_gap);
        chk({tag, ".ready_pattern_bad"}, patt_bad, 0);
        chk({tag, ".ready_outside_accept"}, early_bad, 0);
        chk({tag, ".spacing_bad"}, gap_bad, 0);
    endtask

    task automatic load_table_run(input vec_t v);
        for (int i = 0; i < v.len; i++) begin
            gold_mem[i] = DW'(i);
            s_data[i]   = DW'(i);
            s_last[i]   = (i == v.tlast_at);
        end
        if (v.err_a >= 0) s_data[v.err_a] = v.val_a;
        if (v.err_b >= 0) s_data[v.err_b] = v.val_b;
    endtask

    initial begin
        vec_t rv;
        bit   ready_seen;
        rst_n = 1'b0; start = 1'b0; length = '0; bp_mode = '0;
        sm_tvalid = 1'b0; sm_tdata = '0; sm_tlast = 1'b0;

        //               len mode rnd ea va       eb vb            tl stall poke pass err fidx fgot     fexp tle to hs gap
        tbl[0] = '{8,  0, 0, -1, 32'd0,   -1, 32'd0,        7,  -1, 0,   1,   0,  0,   32'd0,   32'd0, 0, 0, 8,  1};
        tbl[1] = '{8,  0, 0,  3, 32'd100,  6, 32'hFFFFFFFB, 7,  -1, 0,   0,   2,  3,   32'd100, 32'd3, 0, 0, 8,  1};
        tbl[2] = '{4,  0, 0, -1, 32'd0,   -1, 32'd0,        2,  -1, 0,   0,   0,  0,   32'd0,   32'd0, 1, 0, 4,  1};
        tbl[3] = '{16, 1, 0, -1, 32'd0,   -1, 32'd0,        15, -1, 0,   1,   0,  0,   32'd0,   32'd0, 0, 0, 16, 1};
        tbl[4] = '{16, 2, 0, -1, 32'd0,   -1, 32'd0,        15, -1, 0,   1,   0,  0,   32'd0,   32'd0, 0, 0, 16, 1};
        tbl[5] = '{10, 0, 0, -1, 32'd0,   -1, 32'd0,        9,   5, 0,   0,   0,  0,   32'd0,   32'd0, 0, 1, 5,  65};
        tbl[6] = '{6,  3, 0, -1, 32'd0,   -1, 32'd0,        5,  -1, 1,   1,   0,  0,   32'd0,   32'd0, 0, 0, 6,  1};
        tbl[7] = '{1,  0, 0,  0, 32'd7,   -1, 32'd0,        0,  -1, 0,   0,   1,  0,   32'd7,   32'd0, 0, 0, 1,  1};
        tbl[8] = '{5,  1, 1, -1, 32'd0,    4, 32'd9,        4,  -1, 0,   0,   1,  4,   32'd9,   32'd4, 0, 0, 5,  1};

        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            load_table_run(tbl[k]);
            run_vec(tbl[k], $sformatf("tbl%0d", k));
        end

        // randomized runs scored by the reference model
        for (int k = 0; k < 8; k++) begin
            rv = tbl[0];
            rv.len  = $urandom_range(1, 24);
            rv.mode = $urandom_range(0, 3);
            rv.rnd  = 1;
            rv.poke = 0;
            rv.stall = ($urandom_range(0, 4) == 0) ? $urandom_range(1, rv.len) : -1;
            for (int i = 0; i < rv.len; i++) begin
                gold_mem[i] = $urandom;
                s_data[i]   = ($urandom_range(0, 3) == 0) ? $urandom : gold_mem[i];
                s_last[i]   = (i == rv.len - 1) ^ ($urandom_range(0, 9) == 0);
            end
            rv = model(rv);
            run_vec(rv, $sformatf("rnd%0d", k));
        end

        // reset mid-run discards partial results
        @(negedge clk);
        start = 1'b1; length = CW'(8); bp_mode = 2'd0;
        gold_mem[0] = 32'd1; gold_mem[1] = 32'd2;
        @(negedge clk);
        start = 1'b0; sm_tvalid = 1'b1; sm_tdata = 32'd999; sm_tlast = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrun.err_cnt_before_reset", err_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk_reset("midrun");
        sm_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // zero-length run: straight to done with pass and no ready pulse
        ready_seen = 1'b0;
        @(negedge clk);
        ready_seen |= sm_tready;
        start = 1'b1; length = '0; bp_mode = 2'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0.done", done, 1);
        chk("len0.pass", pass, 1);
        chk("len0.busy", busy, 0);
        chk("len0.err_cnt", err_cnt, 0);
        repeat (4) begin
            ready_seen |= sm_tready;
            @(negedge clk);
        end
        chk("len0.no_ready", ready_seen, 0);
        chk("len0.done_held", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_stream_checker.md
# axis_stream_checker

Synthesizable, parametrised AXI-Stream output checker for the FIR lab flow. It sinks the FIR `sm_*` stream and compares every sample against a golden table held in a bram11-style RAM. It also checks `tlast` placement, applies programmable back-pressure, and runs a stall watchdog. Results are exposed as status outputs, so pass/fail can be read on-board without a simulator.

## Interface
Parameters:
- pDATA_WIDTH, 32, stream and golden data width
- pADDR_WIDTH, 12, golden RAM byte-address width
- pCNT_WIDTH, 16, sample-count and index width
- pWDOG_WIDTH, 20, watchdog counter width; timeout fires at 2^pWDOG_WIDTH−1 idle cycles

Ports:
- axis_clk  in  1  sole clock, rising edge
- axis_rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a run; ignored while busy
- length  in  pCNT_WIDTH  expected sample count, sampled on accepted start
- bp_mode  in  2  back-pressure mode, sampled on accepted start:
  - 0: always ready
  - 1: alternate cycles
  - 2: LFSR
  - 3: same as 0
- sm_tvalid  in  1  stream valid
- sm_tdata  in  pDATA_WIDTH  stream data, signed
- sm_tlast  in  1  stream last
- sm_tready  out  1  stream ready
- gold_EN  out  1  golden RAM enable
- gold_A  out  pADDR_WIDTH  golden RAM byte address, equal to index<<2
- gold_Do  in  pDATA_WIDTH  golden RAM data, valid the cycle after EN
- busy  out  1  run in progress
- done  out  1  run finished; held until next accepted start
- pass  out  1  done & err_cnt==0 & !tlast_err & !timeout
- err_cnt  out  pCNT_WIDTH  data mismatches, saturating
- first_err_idx  out  pCNT_WIDTH  index of first mismatch
- first_err_got  out  pDATA_WIDTH  sm_tdata of first mismatch
- first_err_exp  out  pDATA_WIDTH  golden value of first mismatch
- tlast_err  out  1  sticky; tlast misplaced
- timeout  out  1  sticky; watchdog expired

## Operation
- States: IDLE, FETCH, LOAD, ACCEPT, DONE.
- IDLE + start:
  - latch length and mode
  - clear err_cnt, the first_err_* outputs, tlast_err, timeout, idx and the watchdog
  - go to FETCH if length≠0, else to DONE
- FETCH: gold_EN=1, gold_A=idx<<2; go to LOAD.
- LOAD: latch gold_Do into gold_q; go to ACCEPT.
- ACCEPT: sm_tready is driven by mode.
  - Handshake (tvalid&tready): compare sm_tdata against gold_q over the full width.
  - On mismatch: err_cnt+1, saturating at all-ones. If this is the first mismatch, capture idx, got and exp.
  - tlast check: sm_tlast must equal (idx==length−1). Any difference sets tlast_err.
  - After the handshake: if idx==length−1, go to DONE. Otherwise idx+1, and in the same cycle drive gold_EN=1, gold_A=(idx+1)<<2, then go to LOAD.
- DONE: done=1, busy=0. start re-arms (same actions as IDLE+start). done, pass and all error fields stay valid until then.
- Back-pressure:
  - Mode 1 uses toggle bit t, which flips every cycle from reset value 0; tready = (state==ACCEPT)&t.
  - Mode 2 uses a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 at reset, advancing every cycle unconditionally; tready = (state==ACCEPT)&lfsr[0].
  - tready=0 in every state other than ACCEPT.
- Watchdog:
  - In ACCEPT, counts cycles without a handshake and clears on handshake.
  - On reaching all-ones: set timeout and go to DONE; the current sample is not consumed.
- Values presented while tready=0 are never compared or counted.

## Timing
- Reset values:
  - state IDLE
  - sm_tready, gold_EN, busy, done, pass, tlast_err, timeout: all 0
  - err_cnt, the first_err_* outputs, gold_A, idx: all 0
  - t=0, lfsr=16'hACE1
- busy=1 from the cycle after the accepted start until DONE is entered.
- Minimum spacing is 2 cycles per sample (LOAD, ACCEPT).
- First tready is possible 3 cycles after start (FETCH, LOAD, ACCEPT).
- done rises the cycle after the final handshake or watchdog expiry. pass is registered together with done.
- An asynchronous reset mid-run returns immediately to the reset values. No partial results are retained.
- start asserted while busy is ignored, with no state change.

## Test plan
- Length 8, golden = 0..7, stream equal with tlast on sample 7, mode 0: handshakes 2 cycles apart; done after the last handshake; pass=1, err_cnt=0.
- Same run, but sample 3 sent as 100 instead of 3, and sample 6 as −5: err_cnt=2, first_err_idx=3, got=100, exp=3, pass=0.
- Length 4, tlast sent on sample 2 and not on sample 3: tlast_err=1, err_cnt=0, pass=0.
- Mode 1 and mode 2 with tvalid held high, length 16: tready is never high outside ACCEPT; exactly 16 handshakes; pass=1. Mode 1 tready follows t.
- tvalid is stopped after 5 of 10 samples: timeout=1, done=1 after 2^pWDOG_WIDTH−1 stall cycles, pass=0. Run with pWDOG_WIDTH=6.
- Reset asserted mid-run with length 0, then a fresh start: every output matches its reset value, then done=1 and pass=1 with no tready pulse.
